// File: rtl/ariane_pkg.sv
// Shared types for the flush sequencer: FSM states, default fence masks,
// and the bundle of pipeline flush strobes with its decoder.
package ariane_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } flush_state_e;

  localparam logic [1:0] FENCE_MASK_DEFAULT   = 2'b01;
  localparam logic [1:0] FENCE_I_MASK_DEFAULT = 2'b11;

  typedef struct packed {
    logic set_pc_commit;
    logic flush_if;
    logic flush_unissued_instr;
    logic flush_id;
    logic flush_ex;
    logic flush_bp;
    logic flush_tlb;
  } flush_strobes_t;

  // Exceptions, eret and debug entry redirect the PC themselves, so they veto set_pc_commit.
  function automatic flush_strobes_t decode_strobes(
    input logic commit_flush,
    input logic exc_flush,
    input logic mispredict,
    input logic sfence_vma
  );
    flush_strobes_t s;
    s.set_pc_commit        = commit_flush & ~exc_flush;
    s.flush_if             = commit_flush | exc_flush | mispredict;
    s.flush_unissued_instr = commit_flush | exc_flush | mispredict;
    s.flush_id             = commit_flush | exc_flush;
    s.flush_ex             = commit_flush | exc_flush;
    s.flush_bp             = exc_flush | mispredict;
    s.flush_tlb            = sfence_vma;
    return s;
  endfunction

endpackage

// File: rtl/lsb_onehot.sv
// Lowest-set-bit extractor: returns a one-hot copy of the least significant
// set bit of in_i, or zero when in_i is zero.
module lsb_onehot #(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] onehot_o
);

  assign onehot_o = in_i & (~in_i + WIDTH'(1));

endmodule

// File: rtl/flush_sequencer.sv
// Pipeline-flush strobe generator and multi-cache flush sequencer with deferred fences.
// Optional macro FLUSH_TIMEOUT_EN adds a per-episode wait limit with a timeout_o pulse.
module flush_sequencer
  import ariane_pkg::*;
#(
  parameter int unsigned            NR_CACHES      = 2,
  parameter logic [NR_CACHES-1:0]   FENCE_MASK     = FENCE_MASK_DEFAULT,
  parameter logic [NR_CACHES-1:0]   FENCE_I_MASK   = FENCE_I_MASK_DEFAULT,
  parameter bit                     SERIAL         = 1'b0,
  parameter int                     TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fence_i,
  input  logic                 fence_i_i,
  input  logic                 sfence_vma_i,
  input  logic                 flush_csr_i,
  input  logic                 flush_commit_i,
  input  logic                 ex_valid_i,
  input  logic                 eret_i,
  input  logic                 set_debug_pc_i,
  input  logic                 mispredict_i,
  input  logic                 halt_csr_i,
  input  logic [NR_CACHES-1:0] cache_flush_ack_i,
  output logic [NR_CACHES-1:0] cache_flush_req_o,
  output logic                 set_pc_commit_o,
  output logic                 flush_if_o,
  output logic                 flush_unissued_instr_o,
  output logic                 flush_id_o,
  output logic                 flush_ex_o,
  output logic                 flush_bp_o,
  output logic                 flush_tlb_o,
  output logic                 halt_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  flush_state_e         state_q, state_d;
  logic [NR_CACHES-1:0] pend_q, pend_d;
  logic [NR_CACHES-1:0] defer_q, defer_d;
  logic [NR_CACHES-1:0] req_q, req_d;
  logic [NR_CACHES-1:0] new_mask_s;
  logic [NR_CACHES-1:0] acc_s;
  logic [NR_CACHES-1:0] pend_left_s;
  logic [NR_CACHES-1:0] defer_all_s;
  logic [NR_CACHES-1:0] lsb_s;
  flush_strobes_t       strobes_s;

  assign strobes_s = decode_strobes(
    fence_i | fence_i_i | sfence_vma_i | flush_csr_i | flush_commit_i,
    ex_valid_i | eret_i | set_debug_pc_i,
    mispredict_i,
    sfence_vma_i
  );

  assign set_pc_commit_o        = strobes_s.set_pc_commit;
  assign flush_if_o             = strobes_s.flush_if;
  assign flush_unissued_instr_o = strobes_s.flush_unissued_instr;
  assign flush_id_o             = strobes_s.flush_id;
  assign flush_ex_o             = strobes_s.flush_ex;
  assign flush_bp_o             = strobes_s.flush_bp;
  assign flush_tlb_o            = strobes_s.flush_tlb;

  assign new_mask_s = (fence_i   ? FENCE_MASK   : {NR_CACHES{1'b0}}) |
                      (fence_i_i ? FENCE_I_MASK : {NR_CACHES{1'b0}});
  // Only acks that land on a live request retire a cache.
  assign acc_s       = cache_flush_ack_i & req_q;
  assign pend_left_s = pend_q & ~acc_s;
  assign defer_all_s = defer_q | new_mask_s;

  assign busy_o            = (state_q == WAIT);
  assign halt_o            = halt_csr_i | busy_o;
  assign cache_flush_req_o = req_q;

`ifdef FLUSH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg_s;
  assign unused_timeout_cfg_s = (TIMEOUT_CYCLES == 32'sd0);
  assign timeout_o = 1'b0;
`endif

  // Next-state logic for the episode FSM, pending and deferred masks.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    defer_d = defer_q;
    case (state_q)
      IDLE: begin
        if (new_mask_s != {NR_CACHES{1'b0}}) begin
          pend_d  = new_mask_s;
          state_d = WAIT;
        end else begin
          pend_d  = {NR_CACHES{1'b0}};
        end
        defer_d = {NR_CACHES{1'b0}};
      end
      WAIT: begin
        if (pend_left_s != {NR_CACHES{1'b0}}) begin
          pend_d  = pend_left_s;
          defer_d = defer_all_s;
        end else if (defer_all_s != {NR_CACHES{1'b0}}) begin
          pend_d  = defer_all_s;
          defer_d = {NR_CACHES{1'b0}};
        end else begin
          pend_d  = {NR_CACHES{1'b0}};
          defer_d = {NR_CACHES{1'b0}};
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = {NR_CACHES{1'b0}};
        defer_d = {NR_CACHES{1'b0}};
      end
    endcase
`ifdef FLUSH_TIMEOUT_EN
    cnt_d     = {CNT_W{1'b0}};
    timeout_d = 1'b0;
    if (state_q != WAIT) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (acc_s != {NR_CACHES{1'b0}}) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_MAX) begin
      state_d   = IDLE;
      pend_d    = {NR_CACHES{1'b0}};
      defer_d   = {NR_CACHES{1'b0}};
      timeout_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`endif
  end

  lsb_onehot #(
    .WIDTH (NR_CACHES)
  ) u_lsb (
    .in_i     (pend_d),
    .onehot_o (lsb_s)
  );

  // Request register follows the next pending mask, so a request drops the cycle after its ack.
  always_comb begin
    req_d = {NR_CACHES{1'b0}};
    if (state_d == WAIT) begin
      req_d = SERIAL ? lsb_s : pend_d;
    end else begin
      req_d = {NR_CACHES{1'b0}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= {NR_CACHES{1'b0}};
      defer_q <= {NR_CACHES{1'b0}};
      req_q   <= {NR_CACHES{1'b0}};
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      defer_q <= defer_d;
      req_q   <= req_d;
    end
  end

`ifdef FLUSH_TIMEOUT_EN
  // Episode wait counter and timeout pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= {CNT_W{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

endmodule

// File: tb/tb_flush_sequencer.sv
// Directed bench for flush_sequencer: a parallel-mode and a serial-mode instance,
// a strobe vector table, and hand-written multi-cycle flush sequences.
module tb_flush_sequencer;

  logic clk = 1'b0;
  logic rst, fence, fence_ii, sfence, csr, commit, exv, eret, dbg, mis, halt_csr;
  logic [1:0] ack0, ack1, req0, req1;
  logic spc0, fif0, fun0, fid0, fex0, fbp0, ftlb0, halt0, busy0, to0;
  logic spc1, fif1, fun1, fid1, fex1, fbp1, ftlb1, halt1, busy1, to1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  flush_sequencer #(.NR_CACHES(2), .SERIAL(1'b0), .TIMEOUT_CYCLES(8)) dut0 (
    .clk_i(clk), .rst_i(rst), .fence_i(fence), .fence_i_i(fence_ii), .sfence_vma_i(sfence),
    .flush_csr_i(csr), .flush_commit_i(commit), .ex_valid_i(exv), .eret_i(eret),
    .set_debug_pc_i(dbg), .mispredict_i(mis), .halt_csr_i(halt_csr),
    .cache_flush_ack_i(ack0), .cache_flush_req_o(req0),
    .set_pc_commit_o(spc0), .flush_if_o(fif0), .flush_unissued_instr_o(fun0),
    .flush_id_o(fid0), .flush_ex_o(fex0), .flush_bp_o(fbp0), .flush_tlb_o(ftlb0),
    .halt_o(halt0), .busy_o(busy0), .timeout_o(to0)
  );

  flush_sequencer #(.NR_CACHES(2), .SERIAL(1'b1), .TIMEOUT_CYCLES(8)) dut1 (
    .clk_i(clk), .rst_i(rst), .fence_i(fence), .fence_i_i(fence_ii), .sfence_vma_i(sfence),
    .flush_csr_i(csr), .flush_commit_i(commit), .ex_valid_i(exv), .eret_i(eret),
    .set_debug_pc_i(dbg), .mispredict_i(mis), .halt_csr_i(halt_csr),
    .cache_flush_ack_i(ack1), .cache_flush_req_o(req1),
    .set_pc_commit_o(spc1), .flush_if_o(fif1), .flush_unissued_instr_o(fun1),
    .flush_id_o(fid1), .flush_ex_o(fex1), .flush_bp_o(fbp1), .flush_tlb_o(ftlb1),
    .halt_o(halt1), .busy_o(busy1), .timeout_o(to1)
  );

  // ev = {fence, fence.i, sfence.vma, csr, commit, ex_valid, eret, debug, mispredict, halt_csr}
  // exp = {set_pc_commit, if, unissued, id, ex, bp, tlb, halt}
  typedef struct {
    string      name;
    logic [9:0] ev;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    {fence, fence_ii, sfence, csr, commit, exv, eret, dbg, mis, halt_csr} = 10'b0;
    ack0 = 2'b00;
    ack1 = 2'b00;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"none",        10'b0000000000, 8'b0000000_0};
    vecs[1]  = '{"mispredict",  10'b0000000010, 8'b0110010_0};
    vecs[2]  = '{"fence",       10'b1000000000, 8'b1111100_0};
    vecs[3]  = '{"sfence",      10'b0010000000, 8'b1111101_0};
    vecs[4]  = '{"ex_valid",    10'b0000010000, 8'b0111110_0};
    vecs[5]  = '{"ex_plus_csr", 10'b0001010000, 8'b0111110_0};
    vecs[6]  = '{"eret_mispr",  10'b0000001010, 8'b0111110_0};
    vecs[7]  = '{"dbg_sfence",  10'b0010000100, 8'b0111111_0};
    vecs[8]  = '{"halt_csr",    10'b0000000001, 8'b0000000_1};
    vecs[9]  = '{"commit_mis",  10'b0000100010, 8'b1111110_0};
    vecs[10] = '{"fence_i",     10'b0100000000, 8'b1111100_0};

    clear_in();
    rst = 1'b1;
    tick();
    tick();

    // Strobe table, with reset held so the cache FSM stays idle.
    for (int i = 0; i < 11; i++) begin
      {fence, fence_ii, sfence, csr, commit, exv, eret, dbg, mis, halt_csr} = vecs[i].ev;
      #1;
      chk({"strobe_", vecs[i].name}, {24'd0, spc0, fif0, fun0, fid0, fex0, fbp0, ftlb0, halt0},
          {24'd0, vecs[i].exp});
      tick();
    end
    clear_in();

    rst = 1'b0;
    tick();
    chk("reset_req0", {30'd0, req0}, 32'd0);
    chk("reset_req1", {30'd0, req1}, 32'd0);
    chk("reset_busy", {30'd0, busy0, busy1}, 32'd0);
    chk("reset_halt", {31'd0, halt0}, 32'd0);
    chk("reset_to", {30'd0, to0, to1}, 32'd0);

    // Parallel fence: one request, held until its ack.
    do_reset();
    fence = 1'b1; tick(); fence = 1'b0;
    chk("par_fence_req", {30'd0, req0}, 32'h1);
    chk("par_fence_halt", {30'd0, halt0, busy0}, 32'h3);
    tick(); tick();
    chk("par_fence_hold", {30'd0, req0}, 32'h1);
    ack0 = 2'b01; tick(); ack0 = 2'b00;
    chk("par_fence_done", {29'd0, req0, halt0}, 32'h0);
    chk("par_fence_busy", {31'd0, busy0}, 32'h0);

    // fence.i: serial walks 01 then 10; parallel requests 11 at once.
    do_reset();
    fence_ii = 1'b1; tick(); fence_ii = 1'b0;
    chk("ser_req_first", {30'd0, req1}, 32'h1);
    chk("par_req_both", {30'd0, req0}, 32'h3);
    ack1 = 2'b01; tick(); ack1 = 2'b00;
    chk("ser_req_second", {30'd0, req1}, 32'h2);
    chk("ser_busy_mid", {31'd0, busy1}, 32'h1);
    ack1 = 2'b10; tick(); ack1 = 2'b00;
    chk("ser_done", {29'd0, req1, busy1}, 32'h0);
    chk("ser_halt_done", {31'd0, halt1}, 32'h0);
    chk("par_still_waiting", {30'd0, req0}, 32'h3);
    ack0 = 2'b11; tick(); ack0 = 2'b00;
    chk("par_both_done", {29'd0, req0, busy0}, 32'h0);

    // fence.i arriving during a fence flush is deferred and reloaded without an idle cycle.
    do_reset();
    fence = 1'b1; tick(); fence = 1'b0;
    fence_ii = 1'b1; tick(); fence_ii = 1'b0;
    chk("defer_active_unchanged", {30'd0, req0}, 32'h1);
    chk("defer_halt", {31'd0, halt0}, 32'h1);
    ack0 = 2'b01; tick(); ack0 = 2'b00;
    chk("defer_reload", {30'd0, req0}, 32'h3);
    chk("defer_no_idle", {30'd0, busy0, halt0}, 32'h3);
    ack0 = 2'b11; tick(); ack0 = 2'b00;
    chk("defer_done", {29'd0, req0, busy0}, 32'h0);

    // fence in the same cycle the last ack lands starts the next episode seamlessly.
    do_reset();
    fence = 1'b1; tick(); fence = 1'b0;
    fence = 1'b1; ack0 = 2'b01; tick(); fence = 1'b0; ack0 = 2'b00;
    chk("same_cycle_reload", {29'd0, req0, busy0}, 32'h3);
    ack0 = 2'b01; tick(); ack0 = 2'b00;
    chk("same_cycle_done", {29'd0, req0, busy0}, 32'h0);

    // Ack on an unrequested cache is ignored.
    do_reset();
    fence = 1'b1; tick(); fence = 1'b0;
    ack0 = 2'b10; tick(); ack0 = 2'b00;
    chk("stray_ack_ignored", {29'd0, req0, busy0}, 32'h3);
    ack0 = 2'b01; tick(); ack0 = 2'b00;
    chk("stray_then_real", {29'd0, req0, busy0}, 32'h0);

    // Reset mid-flush drops requests and discards deferred work.
    do_reset();
    fence = 1'b1; tick(); fence = 1'b0;
    fence_ii = 1'b1; tick(); fence_ii = 1'b0;
    ack0 = 2'b10; tick(); ack0 = 2'b00;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_req", {30'd0, req0}, 32'h0);
    chk("rst_mid_busy", {30'd0, busy0, halt0}, 32'h0);
    tick();
    chk("rst_defer_discarded", {29'd0, req0, busy0}, 32'h0);

`ifdef FLUSH_TIMEOUT_EN
    do_reset();
    fence = 1'b1; tick(); fence = 1'b0;
    chk("to_enter", {29'd0, req0, to0}, 32'h2);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("to_quiet", {31'd0, to0}, 32'h0);
    end
    tick();
    chk("to_pulse", {31'd0, to0}, 32'h1);
    chk("to_idle", {28'd0, req0, busy0, halt0}, 32'h0);
    tick();
    chk("to_one_cycle", {31'd0, to0}, 32'h0);
`else
    do_reset();
    fence = 1'b1; tick(); fence = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
    end
    chk("no_to_still_req", {29'd0, req0, busy0}, 32'h3);
    chk("no_to_pulse", {30'd0, to0, to1}, 32'h0);
    ack0 = 2'b01; tick(); ack0 = 2'b00;
    chk("no_to_done", {29'd0, req0, busy0}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
